write_buffer: RTL and testbench

//  Receiving end of the cache's eviction interface: stores dirty cachelines pushed by cache_top
//  (write_buffer_en/addr_to_write_buffer/data_to_write_buffer) and drains them to main memory in FIFO order.

---
 rtl/write_buffer_pkg.sv | 21 ++
 rtl/write_buffer_cam.sv | 44 ++++
 rtl/write_buffer.sv | 159 +++++++++++++++
 tb/tb_write_buffer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/write_buffer_pkg.sv
//------------------------------------------------------------------------------
// write_buffer_pkg
// Shared sizing defaults and drain FSM encoding for the eviction write buffer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package write_buffer_pkg;

  localparam int WB_DEPTH  = 4;
  localparam int WB_ADDR_W = 32;
  localparam int WB_LINE_W = 64;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } drain_state_t;

endpackage

`default_nettype wire

// File: rtl/write_buffer_cam.sv
//------------------------------------------------------------------------------
// write_buffer_cam
// Combinational DEPTH-way address compare returning the youngest matching entry.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module write_buffer_cam #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             i_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] i_addr,
  input  logic [PTR_W-1:0]             i_head,
  input  logic [ADDR_W-1:0]            i_key,
  output logic                         o_hit,
  output logic [PTR_W-1:0]             o_idx
);

  logic [DEPTH-1:0] w_match;
  logic [PTR_W-1:0] w_pos;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign w_match[gi] = i_valid[gi] && (i_addr[gi] == i_key);
  end

  // Walk oldest to youngest so the last match seen is the one nearest the tail.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    w_pos = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_pos = i_head + PTR_W'(k);
      if (w_match[w_pos]) begin
        o_hit = 1'b1;
        o_idx = w_pos;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/write_buffer.sv
//------------------------------------------------------------------------------
// write_buffer
// Coalescing FIFO of evicted dirty lines, drained to memory, with refill forwarding.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module write_buffer
  import write_buffer_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int LINE_W = WB_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_buffer_en,
  input  logic [ADDR_W-1:0] addr_to_write_buffer,
  input  logic [LINE_W-1:0] data_to_write_buffer,
  output logic              wb_full,
  output logic              wb_empty,
  input  logic              read_main_memory_en,
  input  logic [ADDR_W-1:0] addr_to_main_memory,
  output logic              wb_fwd_hit,
  output logic [LINE_W-1:0] wb_fwd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [LINE_W-1:0] mem_wr_data,
  input  logic              mem_wr_ack
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [DEPTH-1:0]             r_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0]            r_data [DEPTH];
  logic [c_ptr_w-1:0]           r_head;
  logic [c_ptr_w-1:0]           r_tail;
  logic [c_cnt_w-1:0]           r_count;
  logic                         r_full;
  logic                         r_empty;
  drain_state_t                 r_state;

  logic [DEPTH-1:0]   w_inflight_mask;
  logic               w_merge_hit;
  logic [c_ptr_w-1:0] w_merge_idx;
  logic               w_fwd_raw;
  logic [c_ptr_w-1:0] w_fwd_idx;
  logic               w_merge;
  logic               w_alloc;
  logic               w_pop;
  logic               w_start;
  logic [c_cnt_w-1:0] w_count_next;
  logic [LINE_W-1:0]  w_head_data;

  // The line currently being written to memory must never be modified.
  always_comb begin
    w_inflight_mask = '0;
    if (r_state == ST_WRITE) w_inflight_mask[r_head] = 1'b1;
  end

  write_buffer_cam #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PTR_W(c_ptr_w)) u_merge_cam (
    .i_valid (r_valid & ~w_inflight_mask),
    .i_addr  (r_addr),
    .i_head  (r_head),
    .i_key   (addr_to_write_buffer),
    .o_hit   (w_merge_hit),
    .o_idx   (w_merge_idx)
  );

  write_buffer_cam #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PTR_W(c_ptr_w)) u_fwd_cam (
    .i_valid (r_valid),
    .i_addr  (r_addr),
    .i_head  (r_head),
    .i_key   (addr_to_main_memory),
    .o_hit   (w_fwd_raw),
    .o_idx   (w_fwd_idx)
  );

  assign w_merge      = write_buffer_en && w_merge_hit;
  assign w_alloc      = write_buffer_en && !w_merge_hit && !r_full;
  assign w_pop        = (r_state == ST_WRITE) && mem_wr_ack;
  assign w_start      = (r_state == ST_IDLE) && !r_empty && !read_main_memory_en;
  assign w_count_next = r_count + c_cnt_w'(w_alloc) - c_cnt_w'(w_pop);

  // A merge landing on the head in the same cycle the drain starts must be sent.
  assign w_head_data = (w_merge && (w_merge_idx == r_head)) ? data_to_write_buffer
                                                            : r_data[r_head];

  assign wb_full     = r_full;
  assign wb_empty    = r_empty;
  assign wb_fwd_hit  = read_main_memory_en && w_fwd_raw;
  assign wb_fwd_data = wb_fwd_hit ? r_data[w_fwd_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_addr  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= addr_to_write_buffer;
        r_tail          <= r_tail + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + c_ptr_w'(1);
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == c_cnt_w'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  // Line data carries no reset; validity alone decides whether it is meaningful.
  always_ff @(posedge clk) begin
    if (w_merge) begin
      r_data[w_merge_idx] <= data_to_write_buffer;
    end else if (w_alloc) begin
      r_data[r_tail] <= data_to_write_buffer;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= r_addr[r_head];
            mem_wr_data <= w_head_data;
            r_state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (mem_wr_ack) begin
            mem_wr_en <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_write_buffer.sv
//------------------------------------------------------------------------------
// tb_write_buffer
// Directed vector table, corner sequences and random traffic against a queue model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int LW    = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          write_buffer_en = 1'b0;
  logic [AW-1:0] addr_to_write_buffer = '0;
  logic [LW-1:0] data_to_write_buffer = '0;
  logic          read_main_memory_en = 1'b0;
  logic [AW-1:0] addr_to_main_memory = '0;
  logic          mem_wr_ack = 1'b0;
  logic          wb_full, wb_empty, wb_fwd_hit, mem_wr_en;
  logic [LW-1:0] wb_fwd_data, mem_wr_data;
  logic [AW-1:0] mem_wr_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  write_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .write_buffer_en      (write_buffer_en),
    .addr_to_write_buffer (addr_to_write_buffer),
    .data_to_write_buffer (data_to_write_buffer),
    .wb_full              (wb_full),
    .wb_empty             (wb_empty),
    .read_main_memory_en  (read_main_memory_en),
    .addr_to_main_memory  (addr_to_main_memory),
    .wb_fwd_hit           (wb_fwd_hit),
    .wb_fwd_data          (wb_fwd_data),
    .mem_wr_en            (mem_wr_en),
    .mem_wr_addr          (mem_wr_addr),
    .mem_wr_data          (mem_wr_data),
    .mem_wr_ack           (mem_wr_ack)
  );

  // Reference model: buffer contents as an ordered queue, oldest first.
  typedef struct {
    logic [AW-1:0] a;
    logic [LW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  bit            m_wr = 1'b0;
  logic [AW-1:0] m_wa = '0;
  logic [LW-1:0] m_wd = '0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_find(input logic [AW-1:0] a, input int lo);
    for (int i = mq.size() - 1; i >= lo; i--)
      if (mq[i].a == a) return i;
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_wr = 1'b0;
    m_wa = '0;
    m_wd = '0;
  endtask

  task automatic model_check();
    int f;
    f = read_main_memory_en ? m_find(addr_to_main_memory, 0) : -1;
    chk("m_full", wb_full, mq.size() == DEPTH);
    chk("m_empty", wb_empty, mq.size() == 0);
    chk("m_wr_en", mem_wr_en, m_wr);
    if (m_wr) begin
      chk("m_wr_addr", mem_wr_addr, m_wa);
      chk("m_wr_data", mem_wr_data, m_wd);
    end
    chk("m_fwd_hit", wb_fwd_hit, f >= 0);
    chk("m_fwd_data", wb_fwd_data, (f >= 0) ? mq[f].d : '0);
  endtask

  // Advances the model across one clock edge using the inputs held this cycle.
  task automatic model_step();
    int   sz;
    bit   was_wr;
    int   mi;
    ent_t e;
    sz     = mq.size();
    was_wr = m_wr;
    mi     = write_buffer_en ? m_find(addr_to_write_buffer, was_wr ? 1 : 0) : -1;
    if (mi >= 0) begin
      e      = mq[mi];
      e.d    = data_to_write_buffer;
      mq[mi] = e;
    end
    if (!was_wr && sz > 0 && !read_main_memory_en) begin
      m_wr = 1'b1;
      m_wa = mq[0].a;
      m_wd = mq[0].d;
    end
    if (was_wr && mem_wr_ack) begin
      mq.delete(0);
      m_wr = 1'b0;
    end
    if (write_buffer_en && mi < 0 && sz < DEPTH) begin
      e.a = addr_to_write_buffer;
      e.d = data_to_write_buffer;
      mq.push_back(e);
    end
  endtask

  task automatic apply(input logic p, input logic [AW-1:0] a, input logic [LW-1:0] d,
                       input logic rd, input logic [AW-1:0] pa, input logic ack);
    write_buffer_en      = p;
    addr_to_write_buffer = a;
    data_to_write_buffer = d;
    read_main_memory_en  = rd;
    addr_to_main_memory  = pa;
    mem_wr_ack           = ack;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic          p;
    logic [AW-1:0] a;
    logic [LW-1:0] d;
    logic          rd;
    logic [AW-1:0] pa;
    logic          ack;
    logic          e_full, e_empty, e_wen;
    logic [AW-1:0] e_wa;
    logic [LW-1:0] e_wd;
    logic          e_hit;
    logic [LW-1:0] e_fd;
  } vec_t;

  function automatic vec_t v(input logic p, input logic [AW-1:0] a, input logic [LW-1:0] d,
                             input logic rd, input logic [AW-1:0] pa, input logic ack,
                             input logic ef, input logic ee, input logic ew,
                             input logic [AW-1:0] ewa, input logic [LW-1:0] ewd,
                             input logic eh, input logic [LW-1:0] efd);
    vec_t r;
    r.p = p; r.a = a; r.d = d; r.rd = rd; r.pa = pa; r.ack = ack;
    r.e_full = ef; r.e_empty = ee; r.e_wen = ew; r.e_wa = ewa; r.e_wd = ewd;
    r.e_hit = eh; r.e_fd = efd;
    return r;
  endfunction

  vec_t tbl[30];

  initial begin
    logic          p, rd, ack;
    logic [AW-1:0] a, pa;
    logic [LW-1:0] d;

    // Single line, three-cycle ack; then fill to full and drain in order; then forwarding.
    tbl[0]  = v(1, 'h100, 'hA1, 0, 0,     0,  0, 1, 0, 0,     0,    0, 0);
    tbl[1]  = v(0, 0,     0,    0, 0,     0,  0, 0, 0, 0,     0,    0, 0);
    tbl[2]  = v(0, 0,     0,    0, 0,     0,  0, 0, 1, 'h100, 'hA1, 0, 0);
    tbl[3]  = v(0, 0,     0,    0, 0,     0,  0, 0, 1, 'h100, 'hA1, 0, 0);
    tbl[4]  = v(0, 0,     0,    0, 0,     1,  0, 0, 1, 'h100, 'hA1, 0, 0);
    tbl[5]  = v(0, 0,     0,    0, 0,     0,  0, 1, 0, 0,     0,    0, 0);
    tbl[6]  = v(1, 'h100, 'hB1, 0, 0,     0,  0, 1, 0, 0,     0,    0, 0);
    tbl[7]  = v(1, 'h200, 'hB2, 0, 0,     0,  0, 0, 0, 0,     0,    0, 0);
    tbl[8]  = v(1, 'h300, 'hB3, 0, 0,     0,  0, 0, 1, 'h100, 'hB1, 0, 0);
    tbl[9]  = v(1, 'h400, 'hB4, 0, 0,     0,  0, 0, 1, 'h100, 'hB1, 0, 0);
    tbl[10] = v(0, 0,     0,    0, 0,     0,  1, 0, 1, 'h100, 'hB1, 0, 0);
    tbl[11] = v(0, 0,     0,    0, 0,     1,  1, 0, 1, 'h100, 'hB1, 0, 0);
    tbl[12] = v(0, 0,     0,    0, 0,     0,  0, 0, 0, 0,     0,    0, 0);
    tbl[13] = v(0, 0,     0,    0, 0,     1,  0, 0, 1, 'h200, 'hB2, 0, 0);
    tbl[14] = v(0, 0,     0,    0, 0,     0,  0, 0, 0, 0,     0,    0, 0);
    tbl[15] = v(0, 0,     0,    0, 0,     1,  0, 0, 1, 'h300, 'hB3, 0, 0);
    tbl[16] = v(0, 0,     0,    0, 0,     0,  0, 0, 0, 0,     0,    0, 0);
    tbl[17] = v(0, 0,     0,    0, 0,     1,  0, 0, 1, 'h400, 'hB4, 0, 0);
    tbl[18] = v(0, 0,     0,    0, 0,     0,  0, 1, 0, 0,     0,    0, 0);
    tbl[19] = v(1, 'h100, 'hC1, 1, 'h100, 0,  0, 1, 0, 0,     0,    0, 0);
    tbl[20] = v(1, 'h300, 'hC3, 1, 'h300, 0,  0, 0, 0, 0,     0,    0, 0);
    tbl[21] = v(0, 0,     0,    1, 'h300, 0,  0, 0, 0, 0,     0,    1, 'hC3);
    tbl[22] = v(0, 0,     0,    1, 'h100, 0,  0, 0, 0, 0,     0,    1, 'hC1);
    tbl[23] = v(0, 0,     0,    1, 'h500, 0,  0, 0, 0, 0,     0,    0, 0);
    tbl[24] = v(0, 0,     0,    0, 'h300, 0,  0, 0, 0, 0,     0,    0, 0);
    tbl[25] = v(0, 0,     0,    1, 'h100, 1,  0, 0, 1, 'h100, 'hC1, 1, 'hC1);
    tbl[26] = v(0, 0,     0,    1, 'h100, 0,  0, 0, 0, 0,     0,    0, 0);
    tbl[27] = v(0, 0,     0,    0, 0,     0,  0, 0, 0, 0,     0,    0, 0);
    tbl[28] = v(0, 0,     0,    0, 0,     1,  0, 0, 1, 'h300, 'hC3, 0, 0);
    tbl[29] = v(0, 0,     0,    0, 0,     0,  0, 1, 0, 0,     0,    0, 0);

    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    apply(0, 0, 0, 0, 0, 0);
    chk("rst_wr_addr", mem_wr_addr, '0);
    chk("rst_wr_data", mem_wr_data, '0);
    tick();

    foreach (tbl[i]) begin
      apply(tbl[i].p, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].pa, tbl[i].ack);
      chk($sformatf("v%0d_full", i), wb_full, tbl[i].e_full);
      chk($sformatf("v%0d_empty", i), wb_empty, tbl[i].e_empty);
      chk($sformatf("v%0d_wr_en", i), mem_wr_en, tbl[i].e_wen);
      if (tbl[i].e_wen) begin
        chk($sformatf("v%0d_wr_addr", i), mem_wr_addr, tbl[i].e_wa);
        chk($sformatf("v%0d_wr_data", i), mem_wr_data, tbl[i].e_wd);
      end
      chk($sformatf("v%0d_fwd_hit", i), wb_fwd_hit, tbl[i].e_hit);
      chk($sformatf("v%0d_fwd_data", i), wb_fwd_data, tbl[i].e_fd);
      tick();
    end

    // Coalescing: two pushes to one line before drain give one write of the newer data.
    apply(1, 'h200, 'hD1, 1, 0, 0); tick();
    apply(1, 'h200, 'hD2, 1, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0);
    chk("merge_single_entry", wb_empty, 1'b0);
    tick();
    apply(0, 0, 0, 0, 0, 1);
    chk("merge_wr_en", mem_wr_en, 1'b1);
    chk("merge_wr_data", mem_wr_data, 'hD2);
    tick();
    apply(0, 0, 0, 0, 0, 0);
    chk("merge_empty", wb_empty, 1'b1);
    tick();
    apply(0, 0, 0, 0, 0, 0);
    chk("merge_no_second_write", mem_wr_en, 1'b0);
    tick();

    // A push matching only the in-flight head allocates a second entry.
    apply(1, 'h200, 'hE1, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0); tick();
    apply(1, 'h200, 'hE2, 0, 0, 0);
    chk("inflight_wr_en", mem_wr_en, 1'b1);
    tick();
    apply(0, 0, 0, 0, 0, 1);
    chk("inflight_first_data", mem_wr_data, 'hE1);
    tick();
    apply(0, 0, 0, 0, 0, 0);
    chk("inflight_second_pending", wb_empty, 1'b0);
    tick();
    apply(0, 0, 0, 0, 0, 1);
    chk("inflight_second_data", mem_wr_data, 'hE2);
    tick();
    apply(0, 0, 0, 0, 0, 0);
    chk("inflight_empty", wb_empty, 1'b1);
    tick();

    // Asynchronous reset during a write with three lines held.
    apply(1, 'h100, 'hF1, 0, 0, 0); tick();
    apply(1, 'h200, 'hF2, 0, 0, 0); tick();
    apply(1, 'h300, 'hF3, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0);
    chk("rstmid_wr_en_before", mem_wr_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_wr_en", mem_wr_en, 1'b0);
    chk("rstmid_empty", wb_empty, 1'b1);
    chk("rstmid_full", wb_full, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      apply(0, 0, 0, 0, 0, 1);
      chk("rstmid_ack_ignored", mem_wr_en, 1'b0);
      tick();
    end

    // Random traffic over a small address set to provoke merges and forwarding.
    for (int n = 0; n < 1500; n++) begin
      p   = ($urandom_range(0, 9) < 4);
      a   = AW'(32'h100 * $urandom_range(1, 6));
      d   = {$urandom, $urandom};
      rd  = ($urandom_range(0, 3) == 0);
      pa  = AW'(32'h100 * $urandom_range(1, 6));
      ack = ($urandom_range(0, 1) == 1);
      if (p && mq.size() == DEPTH && m_find(a, m_wr ? 1 : 0) < 0) p = 1'b0;
      apply(p, a, d, rd, pa, ack);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
